// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - switch pad synchroniser, per-bit debouncer and settled-value snapshot
//
// Purpose: brings asynchronous slide-switch pads into clk, accepts a new level per bit only
// after it has persisted for DEBOUNCE_CYCLES cycles, drives the comparator operand buses from
// the debounced value, and keeps a valid/ready snapshot of each settled change.
//
// Ports:
//   clk         in   1     system clock, rising edge
//   rst         in   1     synchronous reset, active-high
//   sw_raw      in   N_SW  asynchronous switch pads
//   sw_stable   out  N_SW  debounced switch state
//   op_a        out  2     sw_stable[1:0]
//   op_b        out  2     sw_stable[3:2]
//   sw_changed  out  1     one-cycle pulse when sw_stable takes a new value
//   out_valid   out  1     snapshot holds an unconsumed value
//   out_data    out  N_SW  snapshot of sw_stable
//   out_ready   in   1     consumer takes out_data when out_valid && out_ready at an edge
//   overrun     out  1     sticky: a snapshot was replaced before being taken
module switch_debouncer #(
    parameter int N_SW            = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_stable,
    output logic [1:0]      op_a,
    output logic [1:0]      op_b,
    output logic            sw_changed,
    output logic            out_valid,
    output logic [N_SW-1:0] out_data,
    input  logic            out_ready,
    output logic            overrun
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_SW-1:0]  sw_pad;
    logic [N_SW-1:0]  sync_1;
    logic [N_SW-1:0]  sync_2;
    logic [N_SW-1:0]  stable_next;
    logic [CNT_W-1:0] cnt      [N_SW];
    logic [CNT_W-1:0] cnt_next [N_SW];
    logic             stable_upd;

    // Inversion sits ahead of the synchroniser so both flops carry the logical level.
    assign sw_pad = ACTIVE_LOW ? ~sw_raw : sw_raw;

    // A bit flips only on the edge where its disagreement count has already reached
    // DEBOUNCE_CYCLES-1; any cycle of agreement drops the count back to zero, so the
    // counter saturates at CNT_LAST and can never wrap.
    always_comb begin
        stable_next = sw_stable;
        for (int i = 0; i < N_SW; i++) begin
            cnt_next[i] = '0;
            if (sync_2[i] != sw_stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_next[i] = sync_2[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    assign stable_upd = (stable_next != sw_stable);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1     <= '0;
            sync_2     <= '0;
            sw_stable  <= '0;
            sw_changed <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            overrun    <= 1'b0;
            for (int i = 0; i < N_SW; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_1     <= sw_pad;
            sync_2     <= sync_1;
            sw_stable  <= stable_next;
            sw_changed <= stable_upd;
            for (int i = 0; i < N_SW; i++) begin
                cnt[i] <= cnt_next[i];
            end
            // A new settled value always wins the snapshot; if the previous one is still
            // waiting and not being taken this edge, it is lost and overrun latches.
            if (stable_upd) begin
                out_data  <= stable_next;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign op_a = sw_stable[1:0];
    assign op_b = sw_stable[3:2];

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - self-checking bench for switch_debouncer
module tb_switch_debouncer;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw_raw = 4'b1111;
    logic       out_ready = 1'b0;
    logic [3:0] sw_stable;
    logic [1:0] op_a;
    logic [1:0] op_b;
    logic       sw_changed;
    logic       out_valid;
    logic [3:0] out_data;
    logic       overrun;

    int vectors = 0;
    int miscompares = 0;

    switch_debouncer #(
        .N_SW(4),
        .DEBOUNCE_CYCLES(DB),
        .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_raw(sw_raw),
        .sw_stable(sw_stable),
        .op_a(op_a),
        .op_b(op_b),
        .sw_changed(sw_changed),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Reference model: pad samples take two edges to become visible; a bit adopts a new
    // level once the last DB visible samples all disagree with its stable level.
    logic [3:0] m_padq [$];
    logic [3:0] m_shist [$];
    logic [3:0] m_stable = '0;
    logic [3:0] m_data = '0;
    logic [3:0] m_nxt;
    logic [3:0] m_s;
    logic       m_changed = 1'b0;
    logic       m_valid = 1'b0;
    logic       m_overrun = 1'b0;
    logic       m_all;

    always @(posedge clk) begin
        if (rst) begin
            m_padq.delete();
            m_padq.push_back(4'b0);
            m_padq.push_back(4'b0);
            m_shist.delete();
            m_stable  = '0;
            m_data    = '0;
            m_changed = 1'b0;
            m_valid   = 1'b0;
            m_overrun = 1'b0;
        end else begin
            m_s = m_padq.pop_front();
            m_padq.push_back(sw_raw);
            m_shist.push_back(m_s);
            if (m_shist.size() > DB) void'(m_shist.pop_front());
            m_nxt = m_stable;
            for (int b = 0; b < 4; b++) begin
                m_all = (m_shist.size() == DB);
                for (int j = 0; j < m_shist.size(); j++)
                    if (m_shist[j][b] == m_stable[b]) m_all = 1'b0;
                if (m_all) m_nxt[b] = m_s[b];
            end
            if (m_nxt != m_stable) begin
                if (m_valid && !out_ready) m_overrun = 1'b1;
                m_data  = m_nxt;
                m_valid = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            m_changed = (m_nxt != m_stable);
            m_stable  = m_nxt;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] dut_pack();
        return {sw_stable, op_a, op_b, sw_changed, out_valid, out_data, overrun};
    endfunction

    // Apply inputs (called at a falling edge), cross one rising edge, compare with the model.
    task automatic step(input logic r, input logic [3:0] sw, input logic rdy);
        rst = r;
        sw_raw = sw;
        out_ready = rdy;
        @(posedge clk);
        @(negedge clk);
        check("model", 32'(dut_pack()),
              32'({m_stable, m_stable[1:0], m_stable[3:2], m_changed, m_valid, m_data, m_overrun}));
    endtask

    typedef struct {
        logic       r;
        logic [3:0] sw;
        logic       rdy;
        logic [3:0] st;
        logic       ch;
        logic       v;
        logic [3:0] d;
        logic       ov;
    } vec_t;

    vec_t tbl [17];
    logic [3:0] bounce;
    logic [3:0] sw_cur;

    initial begin
        // Reset with all pads high, then the high level settles six edges after release.
        tbl[0] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
        tbl[1] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
        for (int i = 2; i <= 6; i++) tbl[i] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
        tbl[7] = '{1'b0, 4'hF, 1'b0, 4'hF, 1'b1, 1'b1, 4'hF, 1'b0};
        tbl[8] = '{1'b0, 4'hF, 1'b1, 4'hF, 1'b0, 1'b0, 4'hF, 1'b0};
        // 0000 -> 0101.
        tbl[9] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
        for (int i = 10; i <= 14; i++) tbl[i] = '{1'b0, 4'h5, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
        tbl[15] = '{1'b0, 4'h5, 1'b0, 4'h5, 1'b1, 1'b1, 4'h5, 1'b0};
        tbl[16] = '{1'b0, 4'h5, 1'b0, 4'h5, 1'b0, 1'b1, 4'h5, 1'b0};

        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].r;
            sw_raw = tbl[i].sw;
            out_ready = tbl[i].rdy;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tbl%0d", i), 32'(dut_pack()),
                  32'({tbl[i].st, tbl[i].st[1:0], tbl[i].st[3:2], tbl[i].ch, tbl[i].v, tbl[i].d, tbl[i].ov}));
        end

        // Bit0 bounces in 3-cycle pulses, then holds high.
        step(1'b1, 4'h0, 1'b0);
        step(1'b0, 4'h0, 1'b0);
        step(1'b0, 4'h0, 1'b0);
        for (int p = 0; p < 4; p++) begin
            bounce = (p % 2 == 0) ? 4'h1 : 4'h0;
            for (int k = 0; k < 3; k++) begin
                step(1'b0, bounce, 1'b0);
                check("bounce_hold", 32'(sw_stable), 32'h0);
            end
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'h1, 1'b0);
            check("bounce_wait", 32'(sw_stable), 32'h0);
        end
        step(1'b0, 4'h1, 1'b0);
        check("bounce_land", 32'({sw_stable, sw_changed}), 32'({4'h1, 1'b1}));

        // Two settled changes while the consumer stalls.
        step(1'b1, 4'h0, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 4'h1, 1'b0);
        check("ovr_first", 32'({out_valid, out_data, overrun}), 32'({1'b1, 4'h1, 1'b0}));
        for (int k = 0; k < 6; k++) step(1'b0, 4'h3, 1'b0);
        check("ovr_second", 32'({out_valid, out_data, overrun}), 32'({1'b1, 4'h3, 1'b1}));
        step(1'b0, 4'h3, 1'b1);
        check("ovr_accept", 32'({out_valid, overrun}), 32'({1'b0, 1'b1}));

        // Accept and update on the same edge.
        step(1'b1, 4'h0, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 4'h1, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 4'h7, 1'b0);
        check("same_pre", 32'({out_valid, out_data}), 32'({1'b1, 4'h1}));
        step(1'b0, 4'h7, 1'b1);
        check("same_edge", 32'({sw_stable, sw_changed, out_valid, out_data, overrun}),
              32'({4'h7, 1'b1, 1'b1, 4'h7, 1'b0}));

        // Reset in the middle of a pending count.
        step(1'b1, 4'h0, 1'b0);
        step(1'b0, 4'h0, 1'b0);
        step(1'b0, 4'h0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 4'h1, 1'b0);
        step(1'b1, 4'h1, 1'b0);
        check("rst_mid", 32'({sw_stable, out_valid}), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'h1, 1'b0);
            check("rst_restart", 32'(sw_stable), 32'h0);
        end
        step(1'b0, 4'h1, 1'b0);
        check("rst_land", 32'({sw_stable, sw_changed}), 32'({4'h1, 1'b1}));

        // Random pads, ready and occasional reset against the model.
        sw_cur = 4'h0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 4) == 0) sw_cur = sw_cur ^ (4'b0001 << $urandom_range(0, 3));
            step(($urandom_range(0, 199) == 0), sw_cur, 1'($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
